serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `diff = a - b`, one bit per clock, LSB first, through a single registered borrow. It is the inverse of the team's one-bit full-adder datapath: a full-subtractor cell time-shared across all bit positions under a small FSM. A start/ready/done handshake makes it a drop-in sequential arithmetic unit for the ALU exercises. It trades WIDTH cycles of latency for one cell's worth of logic.

---
 rtl/serial_arith_pkg.sv | 27 ++
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared types, sizing helper and reset constants for the
//                bit-serial arithmetic units.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    // Sequencer states shared by the serial arithmetic units.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width for a given operand width (never narrower than 1).
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Reset values.
    localparam state_e c_rst_state = IDLE;
    localparam logic   c_rst_bit   = 1'b0;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Combinational one-bit full subtractor, x - y - bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    // A borrow is needed when the subtrahend plus incoming borrow exceeds x.
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first,
//                one full-subtractor cell time-shared under a small FSM with
//                a start/ready/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int                 c_cnt_w    = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_overflow;

    logic               w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_last;

    // The single arithmetic cell, fed from the LSBs of the operand registers.
    full_subtractor u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_bout)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == c_cnt_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, publish on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_borrow     <= c_rst_bit;
            r_cnt        <= '0;
            r_a_msb      <= c_rst_bit;
            r_b_msb      <= c_rst_bit;
            r_diff       <= '0;
            r_borrow_out <= c_rst_bit;
            r_overflow   <= c_rst_bit;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (r_state == SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + c_cnt_one;
            if (w_last) begin
                // The bit computed this cycle is the result MSB.
                r_diff       <= {w_d, r_res_sr[WIDTH-1:1]};
                r_borrow_out <= w_bout;
                r_overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign ready      = (r_state == IDLE);
    assign busy       = (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking scoreboard bench for serial_subtractor (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    exp_t             q_exp[$];
    int               n_tests;
    int               n_fail;
    int               done_cnt;
    int               cyc;
    logic [WIDTH-1:0] prev_diff;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count for throughput measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (q_exp.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("borrow_out", 32'(borrow_out), 32'(e.borrow));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    // One operation from a negedge with ready=1; optionally pulses start with
    // other operands in busy cycle `inject`. Ends on the negedge after done.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int inject);
        exp_t e;
        int   nbusy;
        int   n;
        check("ready_before", 32'(ready), 32'd1);
        e = model(x, y);
        a = x;
        b = y;
        start = 1'b1;
        q_exp.push_back(e);
        @(negedge clk);
        nbusy = 0;
        for (n = 0; n < 50 && !done; n++) begin
            if (busy) nbusy++;
            if (n == 2) check("hold_diff", 32'(diff), 32'(prev_diff));
            start = (inject != 0) && busy && (nbusy == inject);
            if (start) begin
                a = 8'hAA;
                b = 8'h55;
            end else begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("busy_cycles", 32'(nbusy), 32'(WIDTH));
        check("ready_in_done", 32'(ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("ready_after", 32'(ready), 32'd1);
        prev_diff = e.diff;
    endtask

    initial begin
        int   d0;
        int   ndone;
        int   last;
        exp_t e;
        n_tests   = 0;
        n_fail    = 0;
        done_cnt  = 0;
        cyc       = 0;
        prev_diff = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state.
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including signed-overflow corners.
        run_op(8'h05, 8'h03, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'h80, 8'h01, 0);
        run_op(8'h7F, 8'hFF, 0);

        // start pulse in the third busy cycle must be ignored.
        d0 = done_cnt;
        run_op(8'h10, 8'h01, 3);
        repeat (12) @(negedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);

        // Continuous start: one result every WIDTH+2 cycles.
        e = model(8'h5A, 8'hC3);
        for (int i = 0; i < 3; i++) q_exp.push_back(e);
        a = 8'h5A;
        b = 8'hC3;
        start = 1'b1;
        ndone = 0;
        last = 0;
        for (int n = 0; n < 80 && ndone < 3; n++) begin
            @(negedge clk);
            if (done) begin
                if (ndone > 0) check("tput_gap", 32'(cyc - last), 32'(WIDTH + 2));
                last = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("tput_count", 32'(ndone), 32'd3);
        @(negedge clk);
        prev_diff = e.diff;

        // Reset in the fourth busy cycle aborts with no done pulse.
        d0 = done_cnt;
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        run_op(8'h00, 8'h00, 0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd1);

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 0);
        end

        check("queue_empty", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
